// File: rtl/controladora_pkg.sv
// Shared types for the multi-zone lighting controller.
// Zone FSM states and controller operating modes.
package controladora_pkg;

    typedef enum logic [1:0] {
        ZONA_OFF,
        ZONA_ON,
        ZONA_WARN
    } zona_estado_t;

    typedef enum logic {
        MODO_MANUAL,
        MODO_AUTO
    } modo_t;

endpackage

// File: rtl/zona_temporizador.sv
// One lighting zone: OFF/ON/WARN FSM, shutdown timer and warning blink.
// Ports: clk, rst (sync, high), enable (auto mode), clear, presenca, saida.
module zona_temporizador
    import controladora_pkg::*;
#(
    parameter int AUTO_SHUTDOWN_T = 30000,
    parameter int WARN_T          = 5000,
    parameter int BLINK_P         = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic presenca,
    output logic saida
);

    localparam int TW = $clog2(AUTO_SHUTDOWN_T + 1);
    localparam int BW = $clog2(BLINK_P + 1);
    localparam logic [TW-1:0] T_FULL = TW'(AUTO_SHUTDOWN_T);
    localparam logic [TW-1:0] T_WARN = TW'(WARN_T);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_P - 1);

    zona_estado_t  estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          fase_q, fase_d;
    logic          saida_q, saida_d;

    always_comb begin
        estado_d = estado_q;
        timer_d  = timer_q;
        blink_d  = blink_q;
        fase_d   = fase_q;
        if (clear || !enable) begin
            estado_d = ZONA_OFF;
            timer_d  = '0;
            blink_d  = '0;
            fase_d   = 1'b0;
        end else if (presenca) begin
            estado_d = ZONA_ON;
            timer_d  = T_FULL;
            blink_d  = '0;
            fase_d   = 1'b0;
        end else begin
            unique case (estado_q)
                ZONA_ON: begin
                    timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
                    if (timer_d == T_WARN) begin
                        estado_d = ZONA_WARN;
                        blink_d  = '0;
                        fase_d   = 1'b1;
                    end
                end
                ZONA_WARN: begin
                    timer_d = (timer_q != '0) ? timer_q - 1'b1 : '0;
                    if (timer_d == '0) begin
                        estado_d = ZONA_OFF;
                        fase_d   = 1'b0;
                    end else if (blink_q == B_LAST) begin
                        blink_d = '0;
                        fase_d  = ~fase_q;
                    end else begin
                        blink_d = blink_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
        // Output is registered alongside the state so it never glitches.
        saida_d = (estado_d == ZONA_ON) || ((estado_d == ZONA_WARN) && fase_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= ZONA_OFF;
            timer_q  <= '0;
            blink_q  <= '0;
            fase_q   <= 1'b0;
            saida_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
            blink_q  <= blink_d;
            fase_q   <= fase_d;
            saida_q  <= saida_d;
        end
    end

    assign saida = saida_q;

endmodule

// File: rtl/controladora_multizona.sv
// Multi-zone lighting controller: button debounce, short/long press, per-zone timers.
// Ports: clk, rst (sync, high), infravermelho[N], push_button, led (1=auto), saida[N].
module controladora_multizona
    import controladora_pkg::*;
#(
    parameter int N_ZONES           = 4,
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000,
    parameter int AUTO_SHUTDOWN_T   = 30000,
    parameter int WARN_T            = 5000,
    parameter int BLINK_P           = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_ZONES-1:0] infravermelho,
    input  logic               push_button,
    output logic               led,
    output logic [N_ZONES-1:0] saida
);

    localparam int DW = $clog2(DEBOUNCE_P + 1);
    localparam int PW = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_P - 1);
    localparam logic [PW-1:0] PRESS_MAX = PW'(SWITCH_MODE_MIN_T);

    logic               pb_s1_q, pb_s2_q;
    logic [N_ZONES-1:0] ir_s1_q, ir_s2_q;
    logic               db_level_q, db_level_d;
    logic [DW-1:0]      db_cnt_q, db_cnt_d;
    logic [PW-1:0]      press_q, press_d;
    modo_t              modo_q, modo_d;
    logic               manual_on_q, manual_on_d;
    logic               toggle, curta, clear_zonas;
    logic [N_ZONES-1:0] zona_saida;

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (pb_s2_q != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = pb_s2_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        press_d = '0;
        if (db_level_q) begin
            press_d = (press_q == PRESS_MAX) ? press_q : press_q + 1'b1;
        end

        // Long press fires once, when the counter first reaches saturation.
        toggle = db_level_q && (press_q != PRESS_MAX) && (press_d == PRESS_MAX);
        curta  = db_level_q && !db_level_d && (press_q < PRESS_MAX) && !toggle;

        modo_d      = modo_q;
        manual_on_d = manual_on_q;
        clear_zonas = 1'b0;
        if (toggle) begin
            modo_d      = (modo_q == MODO_AUTO) ? MODO_MANUAL : MODO_AUTO;
            manual_on_d = 1'b0;
            clear_zonas = 1'b1;
        end else if (curta) begin
            if (modo_q == MODO_MANUAL) begin
                manual_on_d = ~manual_on_q;
            end else begin
                clear_zonas = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pb_s1_q     <= 1'b0;
            pb_s2_q     <= 1'b0;
            ir_s1_q     <= '0;
            ir_s2_q     <= '0;
            db_level_q  <= 1'b0;
            db_cnt_q    <= '0;
            press_q     <= '0;
            modo_q      <= MODO_MANUAL;
            manual_on_q <= 1'b0;
        end else begin
            pb_s1_q     <= push_button;
            pb_s2_q     <= pb_s1_q;
            ir_s1_q     <= infravermelho;
            ir_s2_q     <= ir_s1_q;
            db_level_q  <= db_level_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
            modo_q      <= modo_d;
            manual_on_q <= manual_on_d;
        end
    end

    for (genvar i = 0; i < N_ZONES; i++) begin : g_zona
        zona_temporizador #(
            .AUTO_SHUTDOWN_T(AUTO_SHUTDOWN_T),
            .WARN_T         (WARN_T),
            .BLINK_P        (BLINK_P)
        ) u_zona (
            .clk     (clk),
            .rst     (rst),
            .enable  (modo_q == MODO_AUTO),
            .clear   (clear_zonas),
            .presenca(ir_s2_q[i]),
            .saida   (zona_saida[i])
        );
    end

    assign led   = (modo_q == MODO_AUTO);
    assign saida = (modo_q == MODO_AUTO) ? zona_saida : {N_ZONES{manual_on_q}};

endmodule

// File: tb/tb_controladora_multizona.sv
// Randomized + directed bench for controladora_multizona.
// Reference model tracks time since last presence per zone and press durations.
module tb_controladora_multizona;

    localparam int NZ  = 4;
    localparam int DEB = 4;
    localparam int SW  = 20;
    localparam int AST = 50;
    localparam int WT  = 10;
    localparam int BP  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NZ-1:0] infravermelho = '0;
    logic          push_button = 1'b0;
    logic          led;
    logic [NZ-1:0] saida;

    controladora_multizona #(
        .N_ZONES          (NZ),
        .DEBOUNCE_P       (DEB),
        .SWITCH_MODE_MIN_T(SW),
        .AUTO_SHUTDOWN_T  (AST),
        .WARN_T           (WT),
        .BLINK_P          (BP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .infravermelho(infravermelho),
        .push_button  (push_button),
        .led          (led),
        .saida        (saida)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model state
    logic          m_pb1, m_pb2;
    logic [NZ-1:0] m_ir1, m_ir2;
    logic          m_level;
    int            m_run, m_held;
    logic          m_auto, m_on;
    int            m_last [NZ];
    bit            m_lit  [NZ];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic zone_out(int i);
        int e;
        if (!m_lit[i]) return 1'b0;
        e = cyc - m_last[i];
        if (e >= AST) return 1'b0;
        if (e < AST - WT) return 1'b1;
        return (((e - (AST - WT)) / BP) % 2) == 0;
    endfunction

    function automatic logic [NZ-1:0] exp_saida();
        logic [NZ-1:0] v;
        if (!m_auto) return {NZ{m_on}};
        for (int i = 0; i < NZ; i++) v[i] = zone_out(i);
        return v;
    endfunction

    task automatic model_reset();
        m_pb1 = 0; m_pb2 = 0; m_ir1 = '0; m_ir2 = '0;
        m_level = 0; m_run = 0; m_held = 0;
        m_auto = 0; m_on = 0;
        for (int i = 0; i < NZ; i++) begin
            m_lit[i] = 0;
            m_last[i] = 0;
        end
    endtask

    task automatic model_edge(input logic r, input logic pb, input logic [NZ-1:0] ir);
        logic new_level, tog, shrt;
        int held_before;
        cyc++;
        if (r) begin
            model_reset();
            return;
        end
        new_level = m_level;
        if (m_pb2 != m_level) begin
            m_run++;
            if (m_run == DEB) begin
                new_level = m_pb2;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        held_before = m_held;
        tog = 0;
        if (m_level) begin
            if (m_held < SW) begin
                m_held++;
                if (m_held == SW) tog = 1;
            end
        end else begin
            m_held = 0;
        end
        shrt = m_level && !new_level && (held_before < SW) && !tog;
        for (int i = 0; i < NZ; i++) begin
            if (tog || (shrt && m_auto)) m_lit[i] = 0;
            else if (m_auto && m_ir2[i]) begin
                m_lit[i] = 1;
                m_last[i] = cyc;
            end
        end
        if (tog) begin
            m_auto = !m_auto;
            m_on = 0;
        end else if (shrt && !m_auto) begin
            m_on = !m_on;
        end
        m_level = new_level;
        m_pb2 = m_pb1; m_pb1 = pb;
        m_ir2 = m_ir1; m_ir1 = ir;
    endtask

    task automatic tick(input logic r, input logic pb, input logic [NZ-1:0] ir);
        @(negedge clk);
        rst = r;
        push_button = pb;
        infravermelho = ir;
        @(posedge clk);
        model_edge(r, pb, ir);
        #1;
        chk("led", 16'(led), 16'(m_auto));
        chk("saida", 16'(saida), 16'(exp_saida()));
    endtask

    task automatic run(input int n, input logic pb, input logic [NZ-1:0] ir);
        for (int k = 0; k < n; k++) tick(1'b0, pb, ir);
    endtask

    initial begin
        model_reset();
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, '0);

        // glitches shorter than the debounce window
        for (int k = 0; k < 6; k++) begin
            run(3, 1'b1, '0);
            run(2, 1'b0, '0);
        end
        run(10, 1'b0, '0);
        chk("glitch_saida", 16'(saida), 16'h0);

        // manual short presses
        run(10, 1'b1, '0);
        run(12, 1'b0, '0);
        chk("man_on", 16'(saida), 16'hF);
        run(10, 1'b1, '0);
        run(12, 1'b0, '0);
        chk("man_off", 16'(saida), 16'h0);

        // long press to auto
        run(30, 1'b1, '0);
        run(12, 1'b0, '0);
        chk("led_auto", 16'(led), 16'h1);

        // single zone pulse, full window
        tick(1'b0, 1'b0, 4'b0100);
        run(60, 1'b0, '0);
        chk("z2_off", 16'(saida), 16'h0);

        // zone 1 retriggered during WARN, zone 3 independent
        tick(1'b0, 1'b0, 4'b1000);
        run(5, 1'b0, '0);
        tick(1'b0, 1'b0, 4'b0010);
        run(44, 1'b0, '0);
        tick(1'b0, 1'b0, 4'b0010);
        run(8, 1'b0, '0);
        chk("z1_relit", 16'(saida & 4'b0010), 16'h2);
        run(55, 1'b0, '0);

        // short press in auto with presence held on zone 0
        tick(1'b0, 1'b0, 4'b1001);
        run(5, 1'b0, '0);
        run(8, 1'b1, 4'b0001);
        run(6, 1'b0, 4'b0001);
        run(44, 1'b0, '0);
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, '0);
        chk("rst_saida", 16'(saida), 16'h0);
        chk("rst_led", 16'(led), 16'h0);

        // randomized segments
        for (int s = 0; s < 60; s++) begin
            int kind, len;
            kind = $urandom_range(0, 4);
            case (kind)
                0: begin
                    len = $urandom_range(1, 60);
                    for (int k = 0; k < len; k++) begin
                        logic [NZ-1:0] ir;
                        ir = '0;
                        for (int z = 0; z < NZ; z++)
                            ir[z] = ($urandom_range(0, 9) == 0);
                        tick(1'b0, 1'b0, ir);
                    end
                end
                1: begin
                    run($urandom_range(1, 3), 1'b1, '0);
                    run($urandom_range(1, 6), 1'b0, '0);
                end
                2: begin
                    run($urandom_range(5, 16), 1'b1, 4'($urandom_range(0, 15)));
                    run($urandom_range(6, 20), 1'b0, '0);
                end
                3: begin
                    run($urandom_range(19, 32), 1'b1, '0);
                    run($urandom_range(6, 20), 1'b0, '0);
                end
                default: begin
                    if ($urandom_range(0, 3) == 0) tick(1'b1, 1'b0, '0);
                    else run($urandom_range(1, 20), 1'b0, 4'($urandom_range(0, 15)));
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/controladora_multizona.md
Name: controladora_multizona

Overview:
Next-generation automatic lighting controller. It drives N_ZONES independent lamp outputs, each with its own infrared presence sensor and auto-shutdown timer, plus a blinking pre-shutdown warning. A single push button selects the mode: a short press acts, a long press toggles manual/automatic. It replaces the single-zone controller at the top of the lighting design.

Parameters:
N_ZONES, 4, number of zones (infrared input / lamp output pairs), 1..16
DEBOUNCE_P, 300, cycles push_button must be stable before the debounced level changes
SWITCH_MODE_MIN_T, 5000, debounced-press cycles that make a long press (mode toggle)
AUTO_SHUTDOWN_T, 30000, cycles a zone stays lit after its last presence sample
WARN_T, 5000, final cycles of the shutdown window spent blinking; must satisfy 0 < WARN_T < AUTO_SHUTDOWN_T
BLINK_P, 500, half-period of the warning blink, in cycles

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
infravermelho  input  N_ZONES  asynchronous presence sensors; bit i is zone i; 1 = presence
push_button  input  1  asynchronous, bouncy button; 1 = pressed
led  output  1  mode indicator: 1 = automatic, 0 = manual
saida  output  N_ZONES  lamp drive; bit i is zone i; 1 = lamp on

Behaviour:
- Reset (rst=1 at a clk edge): mode = manual, led=0, saida=0, all timers 0, manual_on=0, debouncer level 0, press counter 0. Reset asserted mid-count or mid-blink aborts immediately.
- Synchronisers: push_button and each infravermelho bit pass through 2 flops before any use.
- Debounce: the debounced level changes only after the synchronised input differs from it for DEBOUNCE_P consecutive cycles. Any shorter pulse has no effect.
- Press classification:
  - Press counter runs while the debounced level is 1 and saturates at SWITCH_MODE_MIN_T.
  - Long press: on the cycle the counter reaches SWITCH_MODE_MIN_T, mode toggles exactly once. The later release does nothing.
  - Short press: on the debounced falling edge with counter < SWITCH_MODE_MIN_T.
    - Manual mode: if manual_on=1 then manual_on=0, else manual_on=1.
    - Auto mode: all zones are forced to OFF and their timers are cleared.
- Mode transitions:
  - Manual→auto: manual_on=0; all zones start OFF.
  - Auto→manual: all zones go OFF and manual_on=0.
  - led follows mode, registered, in the same cycle as the mode register.
- Manual mode: saida = {N_ZONES{manual_on}}. Infrared is ignored. Timers are held at 0.
- Auto mode, per-zone FSM:
  - States: OFF, ON, WARN.
  - Any state, synchronised infravermelho[i]=1: next state ON, timer[i] = AUTO_SHUTDOWN_T. Continuous presence keeps reloading the timer.
  - ON with no presence: decrement. When the decremented value equals WARN_T, go to WARN and reset the blink counter.
  - WARN with no presence: decrement. When it reaches 0, go to OFF.
  - saida[i]: OFF → 0; ON → 1; WARN → 1 for BLINK_P cycles, then 0 for BLINK_P cycles, repeating.
  - Total lit window after the last presence cycle: exactly AUTO_SHUTDOWN_T cycles.
- Simultaneous events:
  - A short press in auto mode wins over infrared in the same cycle: zones go OFF. Presence on the next cycle re-lights them.
  - A mode toggle wins over every per-zone update in that cycle.
- Widths:
  - Timers: $clog2(AUTO_SHUTDOWN_T+1) bits.
  - Press counter: $clog2(SWITCH_MODE_MIN_T+1) bits.
  - Debounce counter: $clog2(DEBOUNCE_P+1) bits.
  - Blink counter: $clog2(BLINK_P+1) bits.
  - No wrap-around: every down-counter stops at 0.
- Latency:
  - infravermelho edge → saida: 3 cycles (2 sync + 1 state register).
  - Button: 2 sync + DEBOUNCE_P, then 1 cycle to mode/manual_on and outputs.

Decomposition:
- Package controladora_pkg: typedef enum logic [1:0] {ZONA_OFF, ZONA_ON, ZONA_WARN} zona_estado_t; typedef enum logic {MODO_MANUAL, MODO_AUTO} modo_t.
- Sub-module zona_temporizador: one zone's FSM, timer and blink counter.
  - Parameters: AUTO_SHUTDOWN_T, WARN_T, BLINK_P.
  - Ports: clk, rst, enable (auto mode), clear, presenca, saida.
  - Instantiated N_ZONES times with a generate loop.
- Button debounce and press classification stay in the top level.

Test Plan (N_ZONES=4, DEBOUNCE_P=4, SWITCH_MODE_MIN_T=20, AUTO_SHUTDOWN_T=50, WARN_T=10, BLINK_P=2):
1. Reset, then 3-cycle button glitches every 5 cycles → led=0 and saida=4'b0000 throughout.
2. Manual: press held 10 cycles, then released → saida=4'b1111; repeat → 4'b0000; led stays 0.
3. Hold 30 cycles → led rises 2+4+20(+1) cycles after the press edge; release → no further change. Hold 30 again → led=0, saida=0.
4. Auto, 1-cycle pulse on infravermelho[2] → saida[2]=1 from cycle +3 for 40 cycles, then pattern 1,1,0,0,1,1,0,0,1,1, then 0; other bits stay 0.
5. Auto, zone 1 in WARN, pulse infravermelho[1] → back to steady 1 and a full 50-cycle window restarts. Zone 3 is unaffected meanwhile.
6. Auto, zones 0 and 3 lit, short press coincident with infravermelho[0]=1 → saida=4'b0000; next-cycle presence on 0 re-lights only zone 0. rst mid-WARN → all outputs 0, led=0.
